opl3_sample_mixer: RTL and testbench
====================================

// Module: opl3_sample_mixer
// PURPOSE
//  Upstream neighbour of the I2S serializer. Sums the time-multiplexed per-channel
//  left/right outputs of the OPL3 operator pipeline into one stereo frame.
//  Applies gain and signed saturation, then widens the result to DAC_OUTPUT_WIDTH.
//  Presents the frame with a 1-cycle sample_valid pulse, once per sample period.
// PARAMETERS
//  NUM_CHANNELS     18   channel contributions per frame
//  IN_WIDTH         16   signed width of each channel contribution
//  ACC_WIDTH        IN_WIDTH+$clog2(NUM_CHANNELS)   accumulator width (no wrap for <=NUM_CHANNELS)
//  GAIN_SHIFT       0    left shift applied to accumulator before saturation (0..4)
//  DAC_OUTPUT_WIDTH opl3_pkg::DAC_OUTPUT_WIDTH (24)   output sample width, >= IN_WIDTH
// PORTS
//  clk            in   1          system clock
//  reset_n        in   1          asynchronous active-low reset
//  chan_valid     in   1          channel contribution present this cycle
//  chan_last      in   1          qualifies chan_valid: final contribution of frame
//  chan_left      in   IN_WIDTH   signed left contribution
//  chan_right     in   IN_WIDTH   signed right contribution
//  sample_valid   out  1          1-cycle pulse: left/right_channel updated
//  left_channel   out  DAC_OUTPUT_WIDTH   mixed signed left sample, held between pulses
//  right_channel  out  DAC_OUTPUT_WIDTH   mixed signed right sample, held between pulses
//  clip           out  1          1-cycle pulse with sample_valid if either side saturated
//  frame_err      out  1          1-cycle pulse with sample_valid if contribution count != NUM_CHANNELS
//  overrun        out  1          1-cycle pulse when chan_valid arrives in SAT or OUT (input dropped)
// BEHAVIOUR
//  Reset (async, reset_n=0): all outputs 0, state IDLE, accumulators and count 0.
//  FSM states: IDLE -> ACCUM -> SAT -> OUT -> IDLE.
//  - IDLE:
//    - chan_valid loads acc_l/acc_r with sign-extended inputs (load, not add); count=1.
//    - If chan_last is also set -> SAT; otherwise -> ACCUM.
//  - ACCUM:
//    - chan_valid adds the inputs and increments count.
//    - chan_last -> SAT.
//    - When count==NUM_CHANNELS, further contributions are not accumulated; count saturates
//      at NUM_CHANNELS+1, which marks an error.
//  - SAT (1 cycle):
//    - acc <<< GAIN_SHIFT computed at ACC_WIDTH+GAIN_SHIFT width.
//    - Result is clamped to [-2^(IN_WIDTH-1), 2^(IN_WIDTH-1)-1] and registered.
//    - clip_pending and err_pending (count != NUM_CHANNELS) are evaluated.
//  - OUT (1 cycle):
//    - left/right_channel = {sat, (DAC_OUTPUT_WIDTH-IN_WIDTH) zeros}.
//    - sample_valid=1; clip and frame_err pulse in the same cycle. -> IDLE.
//  Latency: chan_last accepted in cycle N -> sample_valid high in cycle N+2.
//  Outputs stay stable until the next sample_valid; the downstream buffer latches on the pulse.
//  chan_valid in SAT or OUT: contribution dropped, overrun=1 that cycle; current frame unaffected.
//  chan_valid in the cycle after OUT (IDLE) is accepted: frames run back-to-back.
//  chan_last with chan_valid=0 is ignored.
//  Reset asserted mid-frame: partial frame discarded, no sample_valid, outputs return to 0.
//  Elaboration check: DAC_OUTPUT_WIDTH >= IN_WIDTH and GAIN_SHIFT <= 4, else $error.
// STRUCTURE
//  opl3_pkg holds:
//    - NUM_CHANNELS and DAC_OUTPUT_WIDTH constants;
//    - typedef enum logic [1:0] {IDLE, ACCUM, SAT, OUT} mixer_state_t.
//  Sub-module sat_clamp #(IN_W, OUT_W): combinational signed clamp with an overflow flag.
//  It is instantiated once per side. Everything else stays in opl3_sample_mixer.
// TESTING
//  1. 18x (L=+1000, R=-1000), shift 0 -> left=0x465000, right=0xB9B000.
//     sample_valid exactly 2 cycles after chan_last; clip=0, frame_err=0.
//  2. 18x L=+32767 -> left=0x7FFF00.
//     18x R=-32768 -> right=0x800000.
//     clip=1 with sample_valid in both cases.
//  3. chan_last on the 17th contribution (all +100) -> left=0x06A400, frame_err=1.
//     20 contributions -> only the first 18 are summed, frame_err=1.
//  4. chan_valid (L=+5000) in the SAT cycle -> overrun=1; emitted frame excludes the 5000.
//  5. reset_n low after 9 contributions, then a full 18x+1 frame -> left=0x001200;
//     no sample_valid during reset.
//  6. Two frames back-to-back, next chan_valid the cycle after OUT -> two pulses 20 cycles apart,
//     both values correct.

Source files
------------

// File: rtl/opl3_pkg.sv
// rtl/opl3_pkg.sv - shared constants and types for the OPL3 output path
//
// Purpose : channel count, DAC sample width and the mixer FSM state type.
// Ports   : none (package).

package opl3_pkg;

    localparam int NUM_CHANNELS     = 18;
    localparam int DAC_OUTPUT_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        SAT,
        OUT
    } mixer_state_t;

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - combinational signed clamp from IN_W to OUT_W bits
//
// Purpose : saturate a wide two's-complement value into OUT_W bits.
// Ports   :
//   din       in   IN_W    signed value to clamp (IN_W > OUT_W)
//   dout      out  OUT_W   clamped signed value
//   overflow  out  1       din was outside the OUT_W signed range

module sat_clamp #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             overflow
);

    // The value fits when every bit from the OUT_W sign bit upward agrees.
    logic [IN_W-OUT_W:0] upper;

    always_comb begin
        upper    = din[IN_W-1:OUT_W-1];
        overflow = ~((&upper) | (~|upper));
        if (!overflow) begin
            dout = din[OUT_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/opl3_sample_mixer.sv
// rtl/opl3_sample_mixer.sv - sums per-channel L/R contributions into one stereo frame
//
// Purpose : accumulate time-multiplexed channel outputs, apply gain and signed
//           saturation, widen to DAC width and present the frame with a pulse.
// Ports   :
//   clk            in   1                 system clock
//   reset_n        in   1                 asynchronous active-low reset
//   chan_valid     in   1                 channel contribution present
//   chan_last      in   1                 final contribution of frame (with chan_valid)
//   chan_left      in   IN_WIDTH          signed left contribution
//   chan_right     in   IN_WIDTH          signed right contribution
//   sample_valid   out  1                 1-cycle pulse, left/right_channel updated
//   left_channel   out  DAC_OUTPUT_WIDTH  mixed signed left sample, held
//   right_channel  out  DAC_OUTPUT_WIDTH  mixed signed right sample, held
//   clip           out  1                 pulse with sample_valid if either side saturated
//   frame_err      out  1                 pulse with sample_valid if count != NUM_CHANNELS
//   overrun        out  1                 contribution arrived in SAT/OUT and was dropped

module opl3_sample_mixer #(
    parameter int NUM_CHANNELS     = opl3_pkg::NUM_CHANNELS,
    parameter int IN_WIDTH         = 16,
    parameter int ACC_WIDTH        = IN_WIDTH + $clog2(NUM_CHANNELS),
    parameter int GAIN_SHIFT       = 0,
    parameter int DAC_OUTPUT_WIDTH = opl3_pkg::DAC_OUTPUT_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        chan_valid,
    input  logic                        chan_last,
    input  logic [IN_WIDTH-1:0]         chan_left,
    input  logic [IN_WIDTH-1:0]         chan_right,
    output logic                        sample_valid,
    output logic [DAC_OUTPUT_WIDTH-1:0] left_channel,
    output logic [DAC_OUTPUT_WIDTH-1:0] right_channel,
    output logic                        clip,
    output logic                        frame_err,
    output logic                        overrun
);

    import opl3_pkg::*;

    generate
        if (DAC_OUTPUT_WIDTH < IN_WIDTH || GAIN_SHIFT < 0 || GAIN_SHIFT > 4) begin : g_param_check
            $error("opl3_sample_mixer: need DAC_OUTPUT_WIDTH >= IN_WIDTH and GAIN_SHIFT in 0..4");
        end
    endgenerate

    // Count must reach NUM_CHANNELS+1, the "too many contributions" marker.
    localparam int                CNT_W    = $clog2(NUM_CHANNELS + 2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_CHANNELS);
    localparam logic [CNT_W-1:0]  CNT_ERR  = CNT_W'(NUM_CHANNELS + 1);
    localparam int                SH_W     = ACC_WIDTH + GAIN_SHIFT;

    mixer_state_t state, state_nxt;

    logic signed [ACC_WIDTH-1:0] acc_l, acc_r;
    logic signed [ACC_WIDTH-1:0] in_l_ext, in_r_ext;
    logic [CNT_W-1:0]            count;
    logic signed [SH_W-1:0]      shl_l, shl_r;
    logic [IN_WIDTH-1:0]         clamp_l, clamp_r;
    logic [IN_WIDTH-1:0]         sat_l, sat_r;
    logic                        ovf_l, ovf_r;
    logic                        clip_pending, err_pending;

    assign in_l_ext = ACC_WIDTH'(signed'(chan_left));
    assign in_r_ext = ACC_WIDTH'(signed'(chan_right));

    // Widen before shifting so the gain cannot wrap before the clamp sees it.
    assign shl_l = SH_W'(acc_l) <<< GAIN_SHIFT;
    assign shl_r = SH_W'(acc_r) <<< GAIN_SHIFT;

    sat_clamp #(.IN_W(SH_W), .OUT_W(IN_WIDTH)) u_clamp_l (
        .din      (shl_l),
        .dout     (clamp_l),
        .overflow (ovf_l)
    );

    sat_clamp #(.IN_W(SH_W), .OUT_W(IN_WIDTH)) u_clamp_r (
        .din      (shl_r),
        .dout     (clamp_r),
        .overflow (ovf_r)
    );

    // Saturated sample sits in the top bits of the DAC word; low bits are zero.
    assign left_channel  = DAC_OUTPUT_WIDTH'(sat_l) << (DAC_OUTPUT_WIDTH - IN_WIDTH);
    assign right_channel = DAC_OUTPUT_WIDTH'(sat_r) << (DAC_OUTPUT_WIDTH - IN_WIDTH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sample_valid = 1'b0;
        clip         = 1'b0;
        frame_err    = 1'b0;
        overrun      = 1'b0;
        case (state)
            IDLE: begin
                if (chan_valid) begin
                    state_nxt = chan_last ? SAT : ACCUM;
                end
            end
            ACCUM: begin
                if (chan_valid && chan_last) begin
                    state_nxt = SAT;
                end
            end
            SAT: begin
                state_nxt = OUT;
                overrun   = chan_valid;
            end
            OUT: begin
                state_nxt    = IDLE;
                sample_valid = 1'b1;
                clip         = clip_pending;
                frame_err    = err_pending;
                overrun      = chan_valid;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_l        <= '0;
            acc_r        <= '0;
            count        <= '0;
            sat_l        <= '0;
            sat_r        <= '0;
            clip_pending <= 1'b0;
            err_pending  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (chan_valid) begin
                        acc_l <= in_l_ext;
                        acc_r <= in_r_ext;
                        count <= CNT_ONE;
                    end
                end
                ACCUM: begin
                    if (chan_valid) begin
                        if (count < CNT_FULL) begin
                            acc_l <= acc_l + in_l_ext;
                            acc_r <= acc_r + in_r_ext;
                            count <= count + CNT_ONE;
                        end else begin
                            count <= CNT_ERR;
                        end
                    end
                end
                SAT: begin
                    sat_l        <= clamp_l;
                    sat_r        <= clamp_r;
                    clip_pending <= ovf_l | ovf_r;
                    err_pending  <= (count != CNT_FULL);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_opl3_sample_mixer.sv
// tb/tb_opl3_sample_mixer.sv - self-checking bench for opl3_sample_mixer

module tb_opl3_sample_mixer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        chan_valid;
    logic        chan_last;
    logic [15:0] chan_left;
    logic [15:0] chan_right;
    logic        sample_valid;
    logic [23:0] left_channel;
    logic [23:0] right_channel;
    logic        clip;
    logic        frame_err;
    logic        overrun;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        clip;
        logic        err;
    } frame_t;

    frame_t exp_q[$];
    frame_t exp_f, act_f;
    int     tests_run    = 0;
    int     tests_failed = 0;
    int     cyc          = 0;

    opl3_sample_mixer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .chan_valid    (chan_valid),
        .chan_last     (chan_last),
        .chan_left     (chan_left),
        .chan_right    (chan_right),
        .sample_valid  (sample_valid),
        .left_channel  (left_channel),
        .right_channel (right_channel),
        .clip          (clip),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [23:0] widen(input int s);
        int          c;
        logic [31:0] v;
        c = s;
        if (c > 32767)  c = 32767;
        if (c < -32768) c = -32768;
        v = c;
        return {v[15:0], 8'h00};
    endfunction

    function automatic frame_t model(input int sl, input int sr, input int n);
        frame_t f;
        f.l    = widen(sl);
        f.r    = widen(sr);
        f.clip = (sl > 32767) || (sl < -32768) || (sr > 32767) || (sr < -32768);
        f.err  = (n != 18);
        return f;
    endfunction

    // Drives n contributions, one per cycle; only the first 18 count toward the sum.
    task automatic send_frame(input int n, input int l, input int r, input bit with_last, input bit push);
        int sl = 0;
        int sr = 0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            chan_valid = 1'b1;
            chan_left  = l[15:0];
            chan_right = r[15:0];
            chan_last  = with_last && (i == n);
            if (i <= 18) begin
                sl += l;
                sr += r;
            end
        end
        if (push) exp_q.push_back(model(sl, sr, n));
    endtask

    // Waits for sample_valid; lat counts negedges after the last contribution was driven.
    task automatic wait_pulse(output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chan_valid = 1'b0;
                chan_last  = 1'b0;
            end
            if (sample_valid) begin
                lat = k;
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        chan_valid = 1'b0;
        chan_last  = 1'b0;
        chan_left  = '0;
        chan_right = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({sample_valid, left_channel, right_channel, clip, frame_err, overrun} !== 52'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got sv=%b L=%h R=%h clip=%b err=%b ovr=%b, expected all 0",
                     sample_valid, left_channel, right_channel, clip, frame_err, overrun);
        end
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({sample_valid, left_channel, right_channel} !== 49'd0) begin
            tests_failed++;
            $display("FAIL reset_release: got sv=%b L=%h R=%h, expected 0", sample_valid, left_channel, right_channel);
        end
    endtask

    task automatic test_basic();
        int lat;
        bit got;
        send_frame(18, 1000, -1000, 1'b1, 1'b1);
        wait_pulse(lat, got);
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL basic_frame: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL basic_latency: got %0d cycles, expected 2", lat);
        end
        @(negedge clk);
        tests_run++;
        if (sample_valid !== 1'b0 || left_channel !== exp_f.l || right_channel !== exp_f.r) begin
            tests_failed++;
            $display("FAIL basic_hold: got sv=%b L=%h R=%h, expected sv=0 L=%h R=%h",
                     sample_valid, left_channel, right_channel, exp_f.l, exp_f.r);
        end
    endtask

    task automatic test_clip();
        int lat;
        bit got;
        send_frame(18, 32767, 0, 1'b1, 1'b1);
        wait_pulse(lat, got);
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL clip_pos: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
        send_frame(18, 0, -32768, 1'b1, 1'b1);
        wait_pulse(lat, got);
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL clip_neg: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
    endtask

    task automatic test_frame_err();
        int lat;
        bit got;
        send_frame(17, 100, 100, 1'b1, 1'b1);
        wait_pulse(lat, got);
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL short_frame: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
        send_frame(20, 300, -7, 1'b1, 1'b1);
        wait_pulse(lat, got);
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL long_frame: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
    endtask

    task automatic test_overrun();
        send_frame(18, 100, 200, 1'b1, 1'b1);
        @(negedge clk);
        chan_last  = 1'b0;
        chan_valid = 1'b1;
        chan_left  = 16'd5000;
        chan_right = 16'd0;
        #1;
        tests_run++;
        if (overrun !== 1'b1 || sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_sat: got ovr=%b sv=%b, expected ovr=1 sv=0", overrun, sample_valid);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (overrun !== 1'b1) begin
            tests_failed++;
            $display("FAIL overrun_out: got ovr=%b, expected 1", overrun);
        end
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (sample_valid !== 1'b1 || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL overrun_frame: got sv=%b L=%h R=%h clip=%b err=%b, expected sv=1 L=%h R=%h clip=%b err=%b",
                     sample_valid, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
        @(negedge clk);
        chan_valid = 1'b0;
        #1;
        tests_run++;
        if (overrun !== 1'b0 || sample_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL overrun_idle: got ovr=%b sv=%b, expected 0 0", overrun, sample_valid);
        end
    endtask

    task automatic test_reset_midframe();
        int lat;
        bit got;
        bit seen = 1'b0;
        send_frame(9, 4000, 4000, 1'b0, 1'b0);
        @(negedge clk);
        chan_valid = 1'b0;
        reset_n    = 1'b0;
        #1;
        tests_run++;
        if (left_channel !== 24'd0 || right_channel !== 24'd0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got L=%h R=%h, expected 0", left_channel, right_channel);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (sample_valid) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL midreset_pulse: got sample_valid during reset, expected none");
        end
        reset_n = 1'b1;
        send_frame(18, 1, -1, 1'b1, 1'b1);
        wait_pulse(lat, got);
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL midreset_frame: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        int t1, t2;
        send_frame(18, 10, -10, 1'b1, 1'b1);
        wait_pulse(lat, got);
        t1    = cyc;
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL b2b_first: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
        send_frame(18, 20, 30, 1'b1, 1'b1);
        wait_pulse(lat, got);
        t2    = cyc;
        exp_f = exp_q.pop_front();
        act_f = {left_channel, right_channel, clip, frame_err};
        tests_run++;
        if (!got || act_f !== exp_f) begin
            tests_failed++;
            $display("FAIL b2b_second: got(%b) L=%h R=%h clip=%b err=%b, expected L=%h R=%h clip=%b err=%b",
                     got, act_f.l, act_f.r, act_f.clip, act_f.err, exp_f.l, exp_f.r, exp_f.clip, exp_f.err);
        end
        tests_run++;
        if (t2 - t1 !== 20) begin
            tests_failed++;
            $display("FAIL b2b_spacing: got %0d cycles between pulses, expected 20", t2 - t1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_frame_err();
        test_overrun();
        test_reset_midframe();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
